// File: rtl/muldiv_pkg.sv
// Shared encodings, default latencies and result container for the HI/LO multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    localparam int          MULT_CYCLES_DEF = 5;
    localparam int          DIV_CYCLES_DEF  = 10;
    localparam logic [31:0] DIV0_FILL       = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_core.sv
// Combinational mult/multu/div/divu producing the 64-bit {hi, lo} result,
// including divide-by-zero and signed-overflow handling.
module muldiv_core
    import muldiv_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output hilo_t       res
);

    logic        sgn;
    logic [63:0] ax, bx, prod;
    logic        neg_a, neg_b, ovf;
    logic [31:0] mag_a, mag_b, dvs, q, r, q_s, r_s;

    assign sgn = (op == OP_MULT) || (op == OP_DIV);

    // low 64 bits of the product of extended operands are exact for both signednesses
    assign ax   = {{32{sgn & a[31]}}, a};
    assign bx   = {{32{sgn & b[31]}}, b};
    assign prod = ax * bx;

    // signed divide via magnitudes: quotient truncates toward zero, remainder follows dividend
    assign neg_a = sgn & a[31];
    assign neg_b = sgn & b[31];
    assign mag_a = neg_a ? (~a + 32'd1) : a;
    assign mag_b = neg_b ? (~b + 32'd1) : b;
    assign dvs   = (b == 32'd0) ? 32'd1 : mag_b;
    assign q     = mag_a / dvs;
    assign r     = mag_a % dvs;
    assign q_s   = (neg_a ^ neg_b) ? (~q + 32'd1) : q;
    assign r_s   = neg_a ? (~r + 32'd1) : r;
    assign ovf   = (op == OP_DIV) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    always_comb begin
        res = '0;
        case (op)
            OP_MULT, OP_MULTU: res = prod;
            default: begin
                if (b == 32'd0)
                    res = '{hi: a, lo: DIV0_FILL};
                else if (ovf)
                    res = '{hi: 32'd0, lo: 32'h8000_0000};
                else
                    res = '{hi: r_s, lo: q_s};
            end
        endcase
    end

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO registers with fixed-latency mult/div sequencing; all state moves on the
// falling clock edge to match the rest of the datapath.
module hilo_muldiv
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_e        state, state_nxt;
    logic [CW-1:0] cnt;
    hilo_t         pend, core_res;
    logic          accept, finish, mt_ok;

    muldiv_core u_core (
        .op  (op),
        .a   (a),
        .b   (b),
        .res (core_res)
    );

    always_ff @(negedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (cnt == CW'(1)) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == ST_RUN);
        accept = (state == ST_IDLE) && start;
        finish = (state == ST_RUN) && (cnt == CW'(1));
        mt_ok  = (state == ST_IDLE) && !start;
    end

    // result is computed at launch and parked until the latency expires
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            pend <= '0;
            done <= 1'b0;
            hi   <= '0;
            lo   <= '0;
        end else begin
            done <= finish;
            if (accept) begin
                pend <= core_res;
                cnt  <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end else if (busy) begin
                cnt <= cnt - CW'(1);
            end
            if (finish) begin
                hi <= pend.hi;
                lo <= pend.lo;
            end else begin
                if (mt_ok && hi_we) hi <= a;
                if (mt_ok && lo_we) lo <= a;
            end
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomized bench for hilo_muldiv against an arithmetic reference model of HI/LO.
module tb_hilo_muldiv;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        rst, start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] hi_m, lo_m;

    always #5 clk = ~clk;

    hilo_muldiv #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'd0: p = 64'(sx * sy);
            2'd1: p = {32'd0, x} * {32'd0, y};
            2'd2: begin
                if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
                else p = {x % y, x / y};
            end
        endcase
        return p;
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit disturb, input string tag);
        logic [63:0] e;
        int          n;
        e = model(o, x, y);
        n = o[1] ? DC : MC;
        start = 1'b1; op = o; a = x; b = y;
        step();
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
        for (int i = 1; i <= n; i++) begin
            chk({tag, ":busy"}, 64'(busy), 64'd1);
            chk({tag, ":done_early"}, 64'(done), 64'd0);
            chk({tag, ":hilo_hold"}, {hi, lo}, {hi_m, lo_m});
            if (disturb && i == 2) begin
                start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; a = 32'h1234; op = 2'($urandom);
            end else begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
            step();
        end
        {hi_m, lo_m} = e;
        chk({tag, ":busy_end"}, 64'(busy), 64'd0);
        chk({tag, ":done"}, 64'(done), 64'd1);
        chk({tag, ":result"}, {hi, lo}, {hi_m, lo_m});
        step();
        chk({tag, ":done_clr"}, 64'(done), 64'd0);
        chk({tag, ":hilo_keep"}, {hi, lo}, {hi_m, lo_m});
    endtask

    task automatic mt(input logic h, input logic l, input logic [31:0] x, input string tag);
        hi_we = h; lo_we = l; a = x;
        step();
        hi_we = 1'b0; lo_we = 1'b0;
        if (h) hi_m = x;
        if (l) lo_m = x;
        chk({tag, ":hilo"}, {hi, lo}, {hi_m, lo_m});
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int          sel;
        rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; op = 2'd0; a = '0; b = '0;
        hi_m = '0; lo_m = '0;
        step(); step();
        chk("rst:busy", 64'(busy), 64'd0);
        chk("rst:done", 64'(done), 64'd0);
        chk("rst:hilo", {hi, lo}, 64'd0);
        rst = 1'b0;
        step();

        run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, "mult_neg");
        run_op(2'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, "multu");
        run_op(2'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, "mult_same");
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg");
        run_op(2'd3, 32'd7, 32'd0, 1'b0, "divu_zero");
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        run_op(2'd1, 32'd1000, 32'd3000, 1'b1, "busy_ignore");
        mt(1'b1, 1'b0, 32'h1234, "mthi");
        mt(1'b0, 1'b1, 32'h5678, "mtlo");
        mt(1'b1, 1'b1, 32'hCAFE_F00D, "mthilo");
        // mthi in the same cycle as start must lose
        hi_we = 1'b1;
        run_op(2'd3, 32'd100, 32'd7, 1'b0, "start_wins");

        start = 1'b1; op = 2'd2; a = 32'd99; b = 32'd4;
        step();
        start = 1'b0;
        step(); step(); step();
        #2 rst = 1'b1;
        #1;
        chk("midrst:busy", 64'(busy), 64'd0);
        chk("midrst:hilo", {hi, lo}, 64'd0);
        hi_m = '0; lo_m = '0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("midrst:no_done", 64'(done), 64'd0);
            chk("midrst:idle", 64'(busy), 64'd0);
        end
        run_op(2'd0, 32'd12345, 32'hFFFF_0000, 1'b0, "post_rst");

        for (int k = 0; k < 40; k++) begin
            ro  = 2'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = 32'($urandom_range(1, 16));
            else if (sel == 3) rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 16));
            if (sel == 4) mt(1'($urandom), 1'($urandom), $urandom, "rnd_mt");
            run_op(ro, ra, rb, 1'($urandom), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Multi-cycle multiply/divide unit holding the architectural HI and LO registers of the MIPS datapath.
- Sits directly downstream of the general-purpose register file: consumes the rs/rt read data (a, b) and produces HI/LO for mfhi/mflo.
- Models fixed mult/div latency with a busy flag, which the controller uses to stall.

Parameters:
- MULT_CYCLES, 5, cycles from accepted mult/multu to HI/LO update (legal range ≥ 1).
- DIV_CYCLES, 10, cycles from accepted div/divu to HI/LO update (legal range ≥ 1).

Ports:
- clk  in  1  clock; all state updates on the falling edge, same as the datapath registers.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  launch the operation selected by op.
- op  in  2  00 mult, 01 multu, 10 div, 11 divu.
- hi_we  in  1  mthi: write a into HI.
- lo_we  in  1  mtlo: write a into LO.
- a  in  32  rs operand (dividend / multiplicand / mthi-mtlo data).
- b  in  32  rt operand (divisor / multiplier).
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse at the edge where HI/LO take the result.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset values: while rst=1 or on its assertion, regardless of clk:
  - busy=0, done=0, hi=0, lo=0.
  - Counter and pending result are cleared.
  - An in-flight operation is discarded.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, counter holds the remaining cycles).
- IDLE, start=1 at edge k:
  - Latch a and b.
  - Compute the 64-bit pending result {hi_n, lo_n} for op.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN, busy=1.
  - HI and LO are unchanged at edge k.
- RUN: counter decrements each edge.
  - At edge k+N (N = cycle count for op): hi<=hi_n, lo<=lo_n, done=1 for that cycle, busy=0, return to IDLE.
  - busy is high for exactly N cycles.
- start while busy=1: ignored. The pending operation is not modified or restarted; the controller is required to stall instead.
- hi_we/lo_we:
  - Honoured only when busy=0 and start=0; the write takes effect at that edge.
  - Ignored when busy=1.
  - Ignored when start=1 in the same cycle (start wins).
- hi_we and lo_we together in IDLE: both registers receive a.
- mult: signed 32x32→64; hi=product[63:32], lo=product[31:0].
- multu: unsigned 32x32→64, same split.
- div:
  - lo = quotient truncated toward zero.
  - hi = remainder, with the sign of the dividend.
- divu: unsigned quotient to lo, remainder to hi.
- Divide by zero (div or divu): lo=32'hFFFF_FFFF, hi=a. No exception.
- Signed overflow (div 32'h8000_0000 / 32'hFFFF_FFFF): lo=32'h8000_0000, hi=0.
- done is never high in IDLE except on the completion edge. A new start may be accepted on the edge after done.
- Operands are latched at start; later changes on a and b have no effect on the result.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - Default latency constants.
  - Divide-by-zero fill value 32'hFFFF_FFFF.
- One sub-module muldiv_core: purely combinational.
  - Inputs: op, a, b. Output: 64-bit {hi_n, lo_n}.
  - Contains the signed/unsigned, div-by-zero and overflow rules.
- hilo_muldiv contains the FSM, counter and HI/LO registers.

Test Plan:
- mult a=32'hFFFF_FFFD (-3), b=5 → busy high 5 cycles, then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFF1, done pulses once.
- multu a=32'hFFFF_FFFF, b=2 → after 5 cycles hi=1, lo=32'hFFFF_FFFE; the same operands with mult give hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFE.
- div a=32'hFFFF_FFF9 (-7), b=2 → busy 10 cycles, lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF. divu a=7, b=0 → lo=32'hFFFF_FFFF, hi=7.
- div a=32'h8000_0000, b=32'hFFFF_FFFF → lo=32'h8000_0000, hi=0.
- While busy:
  - Assert start with other operands, plus hi_we with a=32'h1234 → both ignored; the final HI/LO equal the original operation's result.
  - In IDLE, hi_we with a=32'h1234 → hi=32'h1234 at that edge, lo unchanged.
- Launch div, then assert rst at cycle 4 → busy=0 and hi=lo=0 immediately. After release, no done pulse appears, and a fresh mult completes normally.
